// File: rtl/prog_loader_pkg.sv
// Shared types and stream-format constants for the program loader.
package prog_loader_pkg;

  localparam int unsigned ByteW  = 8;
  localparam int unsigned CountW = 9;

  localparam logic [ByteW-1:0]  BaseAddrDefault = 8'h00;
  localparam logic [CountW-1:0] CountMax        = 9'd256;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StCheck,
    StDone,
    StErr
  } ld_state_e;

endpackage

// File: rtl/ld_addr_counter.sv
// Write-address generator (8-bit wrapping) and payload count (9-bit saturating).
module ld_addr_counter
  import prog_loader_pkg::*;
#(
  parameter logic [ByteW-1:0] BASE_ADDR = BaseAddrDefault
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  output logic [ByteW-1:0]  address,
  output logic [CountW-1:0] count
);

  logic [ByteW-1:0]  address_q;
  logic [CountW-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_q <= BASE_ADDR;
      count_q   <= '0;
    end else if (load) begin
      address_q <= BASE_ADDR;
      count_q   <= '0;
    end else if (inc) begin
      address_q <= address_q + 8'd1;
      if (count_q != CountMax) begin
        count_q <= count_q + 9'd1;
      end
    end
  end

  assign address = address_q;
  assign count   = count_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: length, payload written to memory, checksum verify.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ByteW-1:0] BASE_ADDR       = BaseAddrDefault,
  parameter bit               LEN_ZERO_IS_256 = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [ByteW-1:0]  byte_in,
  output logic              byte_ready,
  output logic [ByteW-1:0]  mem_address,
  output logic [ByteW-1:0]  mem_data,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CountW-1:0] count
);

  ld_state_e         state_q, state_d;
  logic [ByteW-1:0]  acc_q;
  logic [ByteW-1:0]  data_q;
  logic [CountW-1:0] len_q;
  logic [CountW-1:0] len_n;
  logic              xfer;
  logic              load_go;
  logic              last_byte;
  logic              cnt_inc;

  assign xfer = byte_valid & byte_ready;
  assign len_n = (LEN_ZERO_IS_256 && (byte_in == '0)) ? CountMax : {1'b0, byte_in};
  assign load_go = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
  // Compare one bit wider so count+1 cannot overflow at 256.
  assign last_byte = ({1'b0, count} + 10'd1) >= {1'b0, len_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StLen;
      StLen:   if (xfer) state_d = (len_n == '0) ? StCheck : StData;
      StData:  if (xfer) state_d = StWrite;
      StWrite: state_d = last_byte ? StCheck : StData;
      StCheck: if (xfer) state_d = (byte_in == acc_q) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_wren   = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      StLen, StData, StCheck: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
      end
      StWrite: begin
        mem_wren = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        cnt_inc  = 1'b1;
      end
      StDone:  done = 1'b1;
      StErr: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      data_q <= '0;
      len_q  <= '0;
    end else begin
      if (load_go) begin
        acc_q <= '0;
      end else if ((state_q == StData) && xfer) begin
        acc_q  <= acc_q + byte_in;
        data_q <= byte_in;
      end
      if ((state_q == StLen) && xfer) begin
        len_q <= len_n;
      end
    end
  end

  assign mem_data = data_q;

  ld_addr_counter #(
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_counter (
    .clock   (clock),
    .reset   (reset),
    .load    (load_go),
    .inc     (cnt_inc),
    .address (mem_address),
    .count   (count)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: three loader instances (base 00/len0=256, base F0/len0=256, base F0/len0=empty).
module tb_prog_loader;

  logic       clock;
  logic       reset;
  logic       start_v    [3];
  logic       valid_v    [3];
  logic [7:0] byte_in;
  logic       ready_v    [3];
  logic [7:0] addr_v     [3];
  logic [7:0] data_v     [3];
  logic       wren_v     [3];
  logic       hold_v     [3];
  logic       busy_v     [3];
  logic       done_v     [3];
  logic       error_v    [3];
  logic [8:0] count_v    [3];

  int checks;
  int failures;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q [$];
  logic [7:0] pay_q [$];

  prog_loader #(.BASE_ADDR(8'h00), .LEN_ZERO_IS_256(1'b1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .byte_valid(valid_v[0]),
    .byte_in(byte_in), .byte_ready(ready_v[0]), .mem_address(addr_v[0]),
    .mem_data(data_v[0]), .mem_wren(wren_v[0]), .cpu_hold(hold_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .error(error_v[0]), .count(count_v[0])
  );

  prog_loader #(.BASE_ADDR(8'hF0), .LEN_ZERO_IS_256(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .byte_valid(valid_v[1]),
    .byte_in(byte_in), .byte_ready(ready_v[1]), .mem_address(addr_v[1]),
    .mem_data(data_v[1]), .mem_wren(wren_v[1]), .cpu_hold(hold_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .error(error_v[1]), .count(count_v[1])
  );

  prog_loader #(.BASE_ADDR(8'hF0), .LEN_ZERO_IS_256(1'b0)) u_dut2 (
    .clock(clock), .reset(reset), .start(start_v[2]), .byte_valid(valid_v[2]),
    .byte_in(byte_in), .byte_ready(ready_v[2]), .mem_address(addr_v[2]),
    .mem_data(data_v[2]), .mem_wren(wren_v[2]), .cpu_hold(hold_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .error(error_v[2]), .count(count_v[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    for (int g = 0; g < 3; g++) begin
      if (wren_v[g] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: dut%0d wrote %h@%h, expected no write", g,
                   data_v[g], addr_v[g]);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (e.g != 2'(g) || e.a !== addr_v[g] || e.d !== data_v[g]) begin
            failures++;
            $display("FAIL write: dut%0d wrote %h@%h, expected dut%0d %h@%h", g,
                     data_v[g], addr_v[g], e.g, e.d, e.a);
          end
        end
      end
    end
  end

  task automatic pulse_start(input int g);
    @(negedge clock);
    start_v[g] = 1'b1;
    @(negedge clock);
    start_v[g] = 1'b0;
  endtask

  // Presents one byte and returns after the edge that consumes it.
  task automatic send(input int g, input logic [7:0] b, input bit payload,
                      input logic [7:0] addr);
    int n;
    @(negedge clock);
    valid_v[g] = 1'b1;
    byte_in    = b;
    if (payload) exp_q.push_back({2'(g), addr, b});
    n = 0;
    while (ready_v[g] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 32'(ready_v[g]), 32'd1);
      return;
    end
    @(posedge clock);
    if (payload) begin
      @(negedge clock);
      chk("wren_latency", 32'(wren_v[g]), 32'd1);
      chk("ready_in_write", 32'(ready_v[g]), 32'd0);
    end
  endtask

  task automatic stream(input int g, input logic [7:0] base, input logic [7:0] len,
                        input logic [7:0] csum);
    send(g, len, 1'b0, 8'h00);
    for (int i = 0; i < pay_q.size(); i++) begin
      send(g, pay_q[i], 1'b1, base + 8'(i));
    end
    send(g, csum, 1'b0, 8'h00);
    @(negedge clock);
    valid_v[g] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    byte_in  = 8'h00;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      valid_v[g] = 1'b0;
    end
    repeat (3) @(negedge clock);

    // Reset values
    chk("rst_ready", 32'(ready_v[0]), 0);
    chk("rst_wren", 32'(wren_v[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_hold", 32'(hold_v[0]), 0);
    chk("rst_done_err", 32'({done_v[0], error_v[0]}), 0);
    chk("rst_addr0", 32'(addr_v[0]), 32'h00);
    chk("rst_addr1", 32'(addr_v[1]), 32'hF0);
    chk("rst_data", 32'(data_v[0]), 0);
    chk("rst_count", 32'(count_v[0]), 0);
    reset = 1'b0;
    @(negedge clock);

    // Good 3-byte load
    pulse_start(0);
    chk("start_busy", 32'(busy_v[0]), 1);
    chk("start_hold", 32'(hold_v[0]), 1);
    chk("start_ready", 32'(ready_v[0]), 1);
    pay_q = {8'h11, 8'h22, 8'h33};
    stream(0, 8'h00, 8'h03, 8'h66);
    chk("good_done", 32'(done_v[0]), 1);
    chk("good_error", 32'(error_v[0]), 0);
    chk("good_count", 32'(count_v[0]), 3);
    chk("good_hold", 32'(hold_v[0]), 0);
    chk("good_busy", 32'(busy_v[0]), 0);
    chk("good_addr", 32'(addr_v[0]), 32'h03);
    chk("good_drained", 32'(exp_q.size()), 0);

    // Bad checksum: 05+06 = 0B, stream says 0C
    pulse_start(0);
    chk("restart_clear", 32'({done_v[0], error_v[0]}), 0);
    chk("restart_count", 32'(count_v[0]), 0);
    chk("restart_addr", 32'(addr_v[0]), 32'h00);
    pay_q = {8'h05, 8'h06};
    stream(0, 8'h00, 8'h02, 8'h0C);
    chk("bad_error", 32'(error_v[0]), 1);
    chk("bad_done", 32'(done_v[0]), 0);
    chk("bad_count", 32'(count_v[0]), 2);
    repeat (3) @(negedge clock);
    chk("bad_hold", 32'(hold_v[0]), 1);
    chk("bad_drained", 32'(exp_q.size()), 0);

    // Start pulse during DATA is ignored
    pulse_start(0);
    send(0, 8'h03, 1'b0, 8'h00);
    send(0, 8'h01, 1'b1, 8'h00);
    @(negedge clock);
    valid_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    chk("busy_start_addr", 32'(addr_v[0]), 32'h01);
    chk("busy_start_count", 32'(count_v[0]), 1);
    chk("busy_start_state", 32'({busy_v[0], ready_v[0]}), 32'h3);
    send(0, 8'h02, 1'b1, 8'h01);
    send(0, 8'h03, 1'b1, 8'h02);
    send(0, 8'h06, 1'b0, 8'h00);
    @(negedge clock);
    valid_v[0] = 1'b0;
    chk("busy_start_done", 32'(done_v[0]), 1);
    chk("busy_start_total", 32'(count_v[0]), 3);

    // Full 256-byte load from F0, wrapping; sum of 0..255 mod 256 = 80
    pulse_start(1);
    pay_q.delete();
    for (int i = 0; i < 256; i++) pay_q.push_back(8'(i));
    stream(1, 8'hF0, 8'h00, 8'h80);
    chk("full_done", 32'(done_v[1]), 1);
    chk("full_count", 32'(count_v[1]), 256);
    chk("full_addr_wrap", 32'(addr_v[1]), 32'hF0);
    chk("full_drained", 32'(exp_q.size()), 0);

    // Empty load: length 0 means no payload here
    pulse_start(2);
    pay_q.delete();
    stream(2, 8'hF0, 8'h00, 8'h00);
    chk("empty_done", 32'(done_v[2]), 1);
    chk("empty_count", 32'(count_v[2]), 0);
    chk("empty_addr", 32'(addr_v[2]), 32'hF0);

    // Reset after the 2nd payload byte
    pulse_start(0);
    send(0, 8'h04, 1'b0, 8'h00);
    send(0, 8'h10, 1'b1, 8'h00);
    send(0, 8'h20, 1'b1, 8'h01);
    #2;
    reset = 1'b1;
    valid_v[0] = 1'b0;
    #1;
    chk("midrst_wren", 32'(wren_v[0]), 0);
    chk("midrst_busy_hold", 32'({busy_v[0], hold_v[0], ready_v[0]}), 0);
    chk("midrst_addr", 32'(addr_v[0]), 32'h00);
    chk("midrst_data", 32'(data_v[0]), 0);
    chk("midrst_count", 32'(count_v[0]), 0);
    @(negedge clock);
    reset = 1'b0;
    pulse_start(0);
    pay_q = {8'hAA};
    stream(0, 8'h00, 8'h01, 8'hAA);
    chk("postrst_done", 32'(done_v[0]), 1);
    chk("postrst_count", 32'(count_v[0]), 1);
    chk("final_drained", 32'(exp_q.size()), 0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
